// File: rtl/imm_encode.sv
// ============================================================================
// Module   : imm_encode
// Purpose  : Two-stage RISC-V instruction assembler. Takes decoded fields plus
//            a sign-extended immediate and emits a 32-bit instruction word
//            together with a sequential instruction-memory write address.
//            Optional build macro IMM_ENC_RTYPE_EN adds R-type (0110011).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module imm_encode #(
  parameter logic [63:0] BASE_ADDR = 64'h0,
  parameter int          ADDR_W    = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [6:0]        in_opcode,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [63:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_inst,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_err
);

  localparam logic [6:0]        OP_IMM    = 7'b0010011;
  localparam logic [6:0]        OP_LOAD   = 7'b0000011;
  localparam logic [6:0]        OP_STORE  = 7'b0100011;
  localparam logic [6:0]        OP_BRANCH = 7'b1100011;
  localparam logic [6:0]        OP_REG    = 7'b0110011;
  localparam logic [ADDR_W-1:0] C_BASE    = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] C_STEP    = ADDR_W'(4);

  // Stage S1 registers
  logic        s1_v_q,      s1_v_d;
  logic [6:0]  s1_op_q,     s1_op_d;
  logic [4:0]  s1_rd_q,     s1_rd_d;
  logic [4:0]  s1_rs1_q,    s1_rs1_d;
  logic [4:0]  s1_rs2_q,    s1_rs2_d;
  logic [2:0]  s1_f3_q,     s1_f3_d;
  logic [6:0]  s1_f7_q,     s1_f7_d;
  logic [11:0] s1_imm_q,    s1_imm_d;
  logic        s1_rng_q,    s1_rng_d;
  logic        s1_opok_q,   s1_opok_d;

  // Stage S2 / output registers
  logic              out_valid_q, out_valid_d;
  logic [31:0]       out_inst_q,  out_inst_d;
  logic              out_err_q,   out_err_d;
  logic [ADDR_W-1:0] addr_q,      addr_d;

  logic        s2_adv;
  logic        in_fire;
  logic        out_fire;
  logic        range_ok;
  logic        op_ok;
  logic [31:0] asm_inst;
  logic        unused_bits;

  // Handshake: S2 can take a new word when empty or being drained this cycle.
  always_comb begin
    s2_adv   = !out_valid_q || out_ready;
    in_ready = !s1_v_q || !out_valid_q || out_ready;
    in_fire  = in_valid && in_ready;
    out_fire = out_valid_q && out_ready;
  end

  // Classify the incoming bundle: immediate must fit a signed 12-bit field.
  always_comb begin
    range_ok = (&in_imm[63:11]) || !(|in_imm[63:11]);
    op_ok    = 1'b0;
    case (in_opcode)
      OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH: op_ok = 1'b1;
`ifdef IMM_ENC_RTYPE_EN
      OP_REG: begin
        op_ok    = 1'b1;
        range_ok = 1'b1;  // R-type carries no immediate
      end
`endif
      default: op_ok = 1'b0;
    endcase
  end

  // S1 next state: load on accept, empty when its word moves into S2.
  always_comb begin
    s1_op_d   = s1_op_q;
    s1_rd_d   = s1_rd_q;
    s1_rs1_d  = s1_rs1_q;
    s1_rs2_d  = s1_rs2_q;
    s1_f3_d   = s1_f3_q;
    s1_f7_d   = s1_f7_q;
    s1_imm_d  = s1_imm_q;
    s1_rng_d  = s1_rng_q;
    s1_opok_d = s1_opok_q;
    s1_v_d    = s1_v_q && !s2_adv;
    if (in_fire) begin
      s1_v_d    = 1'b1;
      s1_op_d   = in_opcode;
      s1_rd_d   = in_rd;
      s1_rs1_d  = in_rs1;
      s1_rs2_d  = in_rs2;
      s1_f3_d   = in_funct3;
      s1_f7_d   = in_funct7;
      s1_imm_d  = in_imm[11:0];
      s1_rng_d  = range_ok;
      s1_opok_d = op_ok;
    end
  end

  // Assemble the instruction word from the S1 fields.
  always_comb begin
    asm_inst = 32'h0;
    case (s1_op_q)
      OP_IMM, OP_LOAD:
        asm_inst = {s1_imm_q, s1_rs1_q, s1_f3_q, s1_rd_q, s1_op_q};
      OP_STORE:
        asm_inst = {s1_imm_q[11:5], s1_rs2_q, s1_rs1_q, s1_f3_q, s1_imm_q[4:0], s1_op_q};
      OP_BRANCH:  // immediate already in halfword units
        asm_inst = {s1_imm_q[11], s1_imm_q[9:4], s1_rs2_q, s1_rs1_q, s1_f3_q,
                    s1_imm_q[3:0], s1_imm_q[10], s1_op_q};
`ifdef IMM_ENC_RTYPE_EN
      OP_REG:
        asm_inst = {s1_f7_q, s1_rs2_q, s1_rs1_q, s1_f3_q, s1_rd_q, s1_op_q};
`endif
      default: asm_inst = 32'h0;
    endcase
  end

  // S2 next state and address counter; errors do not consume an address.
  always_comb begin
    out_valid_d = out_valid_q;
    out_inst_d  = out_inst_q;
    out_err_d   = out_err_q;
    addr_d      = addr_q;
    if (out_fire && !out_err_q) begin
      addr_d = addr_q + C_STEP;
    end
    if (s2_adv) begin
      out_valid_d = s1_v_q;
      if (s1_v_q) begin
        out_err_d  = !(s1_opok_q && s1_rng_q);
        out_inst_d = (s1_opok_q && s1_rng_q) ? asm_inst : 32'h0;
      end
    end
  end

  // State registers, asynchronously cleared.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_v_q      <= 1'b0;
      s1_op_q     <= 7'h0;
      s1_rd_q     <= 5'h0;
      s1_rs1_q    <= 5'h0;
      s1_rs2_q    <= 5'h0;
      s1_f3_q     <= 3'h0;
      s1_f7_q     <= 7'h0;
      s1_imm_q    <= 12'h0;
      s1_rng_q    <= 1'b0;
      s1_opok_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_inst_q  <= 32'h0;
      out_err_q   <= 1'b0;
      addr_q      <= C_BASE;
    end else begin
      s1_v_q      <= s1_v_d;
      s1_op_q     <= s1_op_d;
      s1_rd_q     <= s1_rd_d;
      s1_rs1_q    <= s1_rs1_d;
      s1_rs2_q    <= s1_rs2_d;
      s1_f3_q     <= s1_f3_d;
      s1_f7_q     <= s1_f7_d;
      s1_imm_q    <= s1_imm_d;
      s1_rng_q    <= s1_rng_d;
      s1_opok_q   <= s1_opok_d;
      out_valid_q <= out_valid_d;
      out_inst_q  <= out_inst_d;
      out_err_q   <= out_err_d;
      addr_q      <= addr_d;
    end
  end

  // Output drive; funct7 is only consumed when R-type support is built in.
  always_comb begin
    out_valid   = out_valid_q;
    out_inst    = out_inst_q;
    out_err     = out_err_q;
    out_addr    = addr_q;
    unused_bits = ^s1_f7_q;
  end

endmodule

`default_nettype wire

// File: doc/imm_encode.md
Name: imm_encode

Overview:
- Pipelined instruction assembler; the encoding counterpart of the decode-side immediate generator.
- Accepts decoded fields (opcode, rd, rs1, rs2, funct3, funct7, 64-bit sign-extended immediate) over a valid/ready handshake.
- Emits a 32-bit RISC-V instruction word plus a sequential instruction-memory write address.
- Used by the testbench/boot loader to fill instruction memory; any word it emits must decode back to the same immediate.

Parameters:
- BASE_ADDR, 64'h0, address of the first emitted instruction.
- ADDR_W, 64, width of out_addr.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  field bundle valid.
- in_ready  output  1  block can accept the bundle this cycle.
- in_opcode  input  7  instruction[6:0].
- in_rd  input  5  destination register.
- in_rs1  input  5  source register 1.
- in_rs2  input  5  source register 2.
- in_funct3  input  3  funct3.
- in_funct7  input  7  funct7; R-type only.
- in_imm  input  64  sign-extended immediate, in decoder units.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- out_inst  output  32  assembled instruction.
- out_addr  output  ADDR_W  write address for out_inst.
- out_err  output  1  bundle rejected; out_inst is 0.

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-high.
- Reset values: out_valid=0, out_inst=0, out_addr=BASE_ADDR, out_err=0, both stage-valid flags=0. in_ready=1 after reset (combinational).
- Reset mid-operation clears both stages immediately; in-flight bundles are dropped; the address returns to BASE_ADDR.
- Stage S1: registers the bundle on in_valid&&in_ready and computes range_ok and op_ok.
- Stage S2: assembles the word and drives the out_* registers.
- Latency: exactly 2 cycles from the accepting edge to out_valid, with out_ready held high. Throughput: 1 per cycle.
- Handshake:
  - in_ready = !s1_v || !s2_v || out_ready.
  - S2 holds out_inst/out_addr/out_err stable while out_valid && !out_ready.
  - No bubble is inserted when both stages advance in the same cycle.
- Range check: range_ok requires in_imm[63:11] all equal to in_imm[11]. Only in_imm[11:0] is encoded.
- Supported opcodes and encodings:
  - 0010011 and 0000011 (I-type): inst = {imm[11:0], rs1, funct3, rd, opcode}.
  - 0100011 (S-type): inst = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}.
  - 1100011 (B-type): immediate is in halfword units. inst[31]=imm[11], inst[7]=imm[10], inst[30:25]=imm[9:4], inst[11:8]=imm[3:0], plus rs2, rs1, funct3, opcode in standard positions.
- Error outputs: any other opcode, or !range_ok, gives out_err=1 and out_inst=32'h0. The result is still presented with out_valid=1 and must be handshaked.
- Address counter:
  - out_addr for each output = current counter value.
  - The counter advances by 4 on each out_valid&&out_ready transfer with out_err=0.
  - Error transfers do not consume an address.
  - Wraps modulo 2^ADDR_W.
- Simultaneous input accept and output transfer in one cycle is legal and must not lose or duplicate a bundle.
- Field widths are fixed. Bits of rs2/funct7 not used by the format are ignored.

Optional Feature:
- Macro: IMM_ENC_RTYPE_EN.
- Defined: opcode 0110011 is supported. inst = {funct7, rs2, rs1, funct3, rd, opcode}. in_imm is ignored and no range check applies.
- Undefined: 0110011 is unsupported and yields out_err=1.

Test Plan:
- addi x1,x0,5: op=0010011, rd=1, rs1=0, f3=0, imm=5 -> out_inst=32'h00500093, out_addr=BASE_ADDR, out_err=0, out_valid 2 cycles after accept.
- Back-to-back, out_ready=1:
  - lw x2,-4(x1) (imm=64'hFFFF_FFFF_FFFF_FFFC, f3=2) -> 32'hFFC0A103 at BASE_ADDR+4.
  - sw x2,8(x1) (op=0100011, rs2=2, f3=2, imm=8) -> 32'h0020A423 at BASE_ADDR+8.
  - beq x1,x2 with imm=4 -> 32'h00208463 at BASE_ADDR+12.
- Out of range, I-type imm=2048 -> out_err=1, out_inst=0; the following valid bundle reuses the unconsumed address.
- Backpressure: out_ready=0 for 5 cycles with 3 bundles offered -> in_ready drops after 2 are accepted, outputs stay stable, then drain in order with consecutive addresses.
- R-type add x3,x1,x2 (op=0110011, f7=0, f3=0) -> 32'h002081B3 with IMM_ENC_RTYPE_EN defined; out_err=1 without it.
- Assert reset while both stages are valid -> out_valid=0 and out_addr=BASE_ADDR immediately, with no clock edge needed.
